// File: rtl/imm_ext_pkg.sv
// Shared definitions for the decode-stage immediate extender.
//   EXT_*   : 2-bit extension mode codes carried on in_mode
//   state_t : occupancy state of the output register / skid pair
package imm_ext_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 2;

  localparam logic [MODE_W-1:0] EXT_ZERO   = 2'b00;
  localparam logic [MODE_W-1:0] EXT_SIGN   = 2'b01;
  localparam logic [MODE_W-1:0] EXT_UPPER  = 2'b10;
  localparam logic [MODE_W-1:0] EXT_BRANCH = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus around the immediate extender.
//   master : upstream/downstream environment (drives in_*, out_ready)
//   slave  : the extender (drives in_ready, out_*)
interface imm_extend_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_imm;
  logic [MODE_W-1:0] in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_neg;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_neg
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_neg
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extension.
//   imm    in  IN_W   raw immediate
//   mode   in  2      EXT_ZERO / EXT_SIGN / EXT_UPPER / EXT_BRANCH
//   ext_c  out OUT_W  extended result
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHAMT = 2
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  ext_c
);

  logic signed [IN_W-1:0] imm_s;
  logic [OUT_W-1:0]       zext;
  logic [OUT_W-1:0]       sext;

  assign imm_s = $signed(imm);
  assign zext  = OUT_W'(imm);
  // Sizing cast of a signed operand replicates the sign bit.
  assign sext  = OUT_W'(imm_s);

  // Mode select; BRANCH drops bits shifted past the MSB.
  always_comb begin
    ext_c = zext;
    case (mode)
      EXT_ZERO:   ext_c = zext;
      EXT_SIGN:   ext_c = sext;
      EXT_UPPER:  ext_c = zext << (OUT_W - IN_W);
      EXT_BRANCH: ext_c = sext << SHAMT;
      default:    ext_c = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a 2-entry (out reg + skid) buffer.
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, dominates flush
//   flush  in   discard all held entries at the next edge
//   bus    slave modport: in_valid/in_ready/in_imm/in_mode/in_tag,
//          out_valid/out_ready/out_data/out_tag/out_neg
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHAMT = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  imm_extend_pipe_if.slave  bus
);

  // Shifted branch offsets must fit the datapath.
  if (OUT_W < IN_W + SHAMT) begin : g_bad_params
    $error("imm_extend_pipe: OUT_W must be >= IN_W + SHAMT");
  end

  state_t           state_q, state_d;
  logic [OUT_W-1:0] ext_c;
  logic [OUT_W-1:0] out_data_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [OUT_W-1:0] skid_data_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             accept_c;
  logic             deliver_c;
  logic             load_in_c;
  logic             load_skid_c;
  logic             skid_to_out_c;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHAMT (SHAMT)
  ) u_core (
    .imm   (bus.in_imm),
    .mode  (bus.in_mode),
    .ext_c (ext_c)
  );

  assign accept_c  = bus.in_valid && in_ready_q;
  assign deliver_c = out_valid_q && bus.out_ready;

  // Next state and register load enables.
  always_comb begin
    state_d       = state_q;
    load_in_c     = 1'b0;
    load_skid_c   = 1'b0;
    skid_to_out_c = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d   = ST_ONE;
            load_in_c = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_c && !deliver_c) begin
            state_d     = ST_FULL;
            load_skid_c = 1'b1;
          end else if (accept_c && deliver_c) begin
            load_in_c = 1'b1;
          end else if (deliver_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no accept can coincide.
          if (deliver_c) begin
            state_d       = ST_ONE;
            skid_to_out_c = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, handshake flags and data registers; flags are decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_FULL);
      if (load_in_c) begin
        out_data_q <= ext_c;
        out_tag_q  <= bus.in_tag;
      end else if (skid_to_out_c) begin
        out_data_q <= skid_data_q;
        out_tag_q  <= skid_tag_q;
      end
      if (load_skid_c) begin
        skid_data_q <= ext_c;
        skid_tag_q  <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_neg   = out_data_q[OUT_W-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default-parameter instance plus a
// wide (IN_W=12, OUT_W=64, SHAMT=1) instance.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus  ();
  imm_extend_pipe_if #(.IN_W(12), .OUT_W(64), .TAG_W(5)) bus2 ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2), .TAG_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(64), .SHAMT(1), .TAG_W(5)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm, input logic [4:0] tag);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_imm   = imm;
    bus.in_tag   = tag;
  endtask

  task automatic drive2(input logic v, input logic [1:0] m, input logic [11:0] imm, input logic [4:0] tag);
    bus2.in_valid = v;
    bus2.in_mode  = m;
    bus2.in_imm   = imm;
    bus2.in_tag   = tag;
  endtask

  initial begin
    vecs[0] = '{EXT_ZERO,   16'h8000, 5'd1, 32'h0000_8000};
    vecs[1] = '{EXT_SIGN,   16'h8000, 5'd2, 32'hFFFF_8000};
    vecs[2] = '{EXT_UPPER,  16'h8000, 5'd3, 32'h8000_0000};
    vecs[3] = '{EXT_BRANCH, 16'hFFFF, 5'd4, 32'hFFFF_FFFC};
    vecs[4] = '{EXT_ZERO,   16'hFFFF, 5'd5, 32'h0000_FFFF};
    vecs[5] = '{EXT_SIGN,   16'h7FFF, 5'd6, 32'h0000_7FFF};
    vecs[6] = '{EXT_UPPER,  16'h1234, 5'd7, 32'h1234_0000};
    vecs[7] = '{EXT_BRANCH, 16'h4000, 5'd8, 32'h0001_0000};
    vecs[8] = '{EXT_BRANCH, 16'h8000, 5'd9, 32'hFFFE_0000};

    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b0, EXT_ZERO, 16'h0, 5'd0);
    drive2(1'b0, EXT_ZERO, 12'h0, 5'd0);
    bus.out_ready  = 1'b1;
    bus2.out_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
    chk("rst_out_neg",   64'(bus.out_neg),   64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    rst = 1'b0;
    step();

    // Modes and back-to-back stream, out_ready held high
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].imm, vecs[i].tag);
      chk($sformatf("stream_in_ready[%0d]", i), 64'(bus.in_ready), 64'd1);
      step();
      chk($sformatf("stream_valid[%0d]", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stream_data[%0d]", i),  64'(bus.out_data),  64'(vecs[i].exp));
      chk($sformatf("stream_tag[%0d]", i),   64'(bus.out_tag),   64'(vecs[i].tag));
      chk($sformatf("stream_neg[%0d]", i),   64'(bus.out_neg),   64'(vecs[i].exp[31]));
    end
    drive(1'b0, EXT_ZERO, 16'h0, 5'd0);
    step();
    chk("stream_drain_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: A then B held, then released in order
    bus.out_ready = 1'b0;
    drive(1'b1, EXT_SIGN, 16'h0001, 5'd10);
    step();
    chk("bp_a_valid",    64'(bus.out_valid), 64'd1);
    chk("bp_a_ready",    64'(bus.in_ready),  64'd1);
    drive(1'b1, EXT_ZERO, 16'hBEEF, 5'd11);
    step();
    drive(1'b0, EXT_ZERO, 16'h0, 5'd0);
    chk("bp_full_ready", 64'(bus.in_ready),  64'd0);
    chk("bp_hold_data0", 64'(bus.out_data),  64'h0000_0001);
    step();
    chk("bp_hold_data1", 64'(bus.out_data),  64'h0000_0001);
    chk("bp_hold_tag1",  64'(bus.out_tag),   64'd10);
    chk("bp_hold_ready", 64'(bus.in_ready),  64'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_a_out_tag",  64'(bus.out_tag),   64'd10);
    step();
    chk("bp_b_valid",    64'(bus.out_valid), 64'd1);
    chk("bp_b_data",     64'(bus.out_data),  64'h0000_BEEF);
    chk("bp_b_tag",      64'(bus.out_tag),   64'd11);
    chk("bp_b_ready",    64'(bus.in_ready),  64'd1);
    step();
    chk("bp_empty",      64'(bus.out_valid), 64'd0);

    // Flush in FULL with an input offered
    bus.out_ready = 1'b0;
    drive(1'b1, EXT_ZERO, 16'h00C0, 5'd12);
    step();
    drive(1'b1, EXT_ZERO, 16'h00D0, 5'd13);
    step();
    chk("fl_full_ready", 64'(bus.in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, EXT_ZERO, 16'h00E0, 5'd14);
    step();
    flush = 1'b0;
    drive(1'b0, EXT_ZERO, 16'h0, 5'd0);
    bus.out_ready = 1'b1;
    chk("fl_full_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_full_ready2", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_full_quiet[%0d]", k), 64'(bus.out_valid), 64'd0);
    end

    // Flush in ONE beats a simultaneous accept
    bus.out_ready = 1'b0;
    drive(1'b1, EXT_ZERO, 16'h00F0, 5'd15);
    step();
    chk("fl_one_valid", 64'(bus.out_valid), 64'd1);
    flush = 1'b1;
    drive(1'b1, EXT_SIGN, 16'hFFFF, 5'd16);
    step();
    flush = 1'b0;
    drive(1'b0, EXT_ZERO, 16'h0, 5'd0);
    bus.out_ready = 1'b1;
    chk("fl_one_cleared", 64'(bus.out_valid), 64'd0);
    step();
    chk("fl_one_dropped", 64'(bus.out_valid), 64'd0);

    // Reset mid-operation in ONE with an input offered
    bus.out_ready = 1'b0;
    drive(1'b1, EXT_UPPER, 16'hFFFF, 5'd17);
    step();
    chk("mr_one_data", 64'(bus.out_data), 64'hFFFF_0000);
    rst = 1'b1;
    drive(1'b1, EXT_ZERO, 16'h1111, 5'd18);
    step();
    rst = 1'b0;
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_data",  64'(bus.out_data),  64'd0);
    chk("mr_tag",   64'(bus.out_tag),   64'd0);
    chk("mr_neg",   64'(bus.out_neg),   64'd0);
    bus.out_ready = 1'b1;
    drive(1'b1, EXT_BRANCH, 16'h0003, 5'd19);
    chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    drive(1'b0, EXT_ZERO, 16'h0, 5'd0);
    chk("mr_post_valid", 64'(bus.out_valid), 64'd1);
    chk("mr_post_data",  64'(bus.out_data),  64'h0000_000C);
    chk("mr_post_tag",   64'(bus.out_tag),   64'd19);
    step();
    chk("mr_post_empty", 64'(bus.out_valid), 64'd0);

    // Wide instance: IN_W=12, OUT_W=64, SHAMT=1
    drive2(1'b1, EXT_SIGN, 12'h800, 5'd1);
    step();
    chk("w_sign_data", bus2.out_data, 64'hFFFF_FFFF_FFFF_F800);
    chk("w_sign_neg",  64'(bus2.out_neg), 64'd1);
    drive2(1'b1, EXT_BRANCH, 12'h001, 5'd2);
    step();
    chk("w_branch_data", bus2.out_data, 64'h0000_0000_0000_0002);
    chk("w_branch_tag",  64'(bus2.out_tag), 64'd2);
    drive2(1'b1, EXT_UPPER, 12'hABC, 5'd3);
    step();
    chk("w_upper_data", bus2.out_data, 64'hABC0_0000_0000_0000);
    drive2(1'b1, EXT_BRANCH, 12'h800, 5'd4);
    step();
    chk("w_branch_neg_data", bus2.out_data, 64'hFFFF_FFFF_FFFF_F000);
    drive2(1'b0, EXT_ZERO, 12'h0, 5'd0);
    step();
    chk("w_empty", 64'(bus2.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
